fetch_pc_ctrl: RTL

- Fetch-side consumer of the execute-stage branch redirect (taken flag plus target) produced by the branch unit.
- Owns the architectural PC register and drives instruction-memory fetch.
- Applies redirects, generates the IF/ID and ID/EX flush pulses, absorbs instruction-memory backpressure, and flags malformed targets.
- Sits between the branch unit and the IF stage / IF-ID pipeline register.

---
 rtl/fetch_pc_ctrl.sv | 120 ++++++++++++
 1 files changed

// File: rtl/fetch_pc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pc_ctrl
// Description : Fetch-side PC owner. Applies execute-stage branch redirects,
//               produces IF/ID and ID/EX flush pulses, parks a redirect while
//               instruction memory is busy, sanitises and flags bad targets,
//               and counts accepted redirects.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_pc_ctrl #(
    parameter int          PC_W     = 9,
    parameter logic [31:0] RESET_PC = 32'd0,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             stall,
    input  logic             redir_valid,
    input  logic [31:0]      redir_pc,
    input  logic             imem_ready,
    output logic [PC_W-1:0]  pc,
    output logic [31:0]      pc_four,
    output logic             fetch_valid,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic [1:0]       redir_err,
    output logic [CNT_W-1:0] taken_count
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam logic [PC_W-1:0]  c_reset_pc = RESET_PC[PC_W-1:0];
    localparam logic [PC_W-1:0]  c_pc_step  = PC_W'(4);
    localparam logic [CNT_W-1:0] c_cnt_max  = '1;

    state_t           r_state;
    logic [PC_W-1:0]  r_pc;
    logic [PC_W-1:0]  r_pend;
    logic [1:0]       r_err;
    logic [CNT_W-1:0] r_cnt;

    logic             w_accept;
    logic [PC_W-1:0]  w_tgt;
    logic [31:0]      w_above;
    logic             w_err_lo;
    logic             w_err_hi;

    // A redirect is honoured in every state except the single boot cycle.
    assign w_accept = redir_valid && (r_state != ST_BOOT);

    // Word-align the target and keep only the bits the PC can hold.
    assign w_tgt    = {redir_pc[PC_W-1:2], 2'b00};
    assign w_above  = redir_pc >> PC_W;
    assign w_err_lo = |redir_pc[1:0];
    assign w_err_hi = |w_above;

    assign pc          = r_pc;
    assign pc_four     = {{(32-PC_W){1'b0}}, r_pc} + 32'd4;
    assign fetch_valid = (r_state == ST_RUN) && imem_ready && !stall && !redir_valid;
    assign flush_ifid  = w_accept;
    assign flush_idex  = w_accept;
    assign redir_err   = r_err;
    assign taken_count = r_cnt;

    // PC sequencing FSM plus sticky error flags and saturating redirect count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_BOOT;
            r_pc    <= c_reset_pc;
            r_pend  <= '0;
            r_err   <= 2'b00;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_BOOT: begin
                    r_state <= ST_RUN;
                end
                ST_RUN: begin
                    if (redir_valid) begin
                        if (imem_ready) begin
                            r_pc <= w_tgt;
                        end else begin
                            r_pend  <= w_tgt;
                            r_state <= ST_HOLD;
                        end
                    end else if (imem_ready && !stall) begin
                        r_pc <= r_pc + c_pc_step;
                    end
                end
                ST_HOLD: begin
                    // A fresh redirect replaces the parked one; if memory is
                    // ready in the same cycle the fresh target goes straight in.
                    if (redir_valid) begin
                        r_pend <= w_tgt;
                    end
                    if (imem_ready) begin
                        r_pc    <= redir_valid ? w_tgt : r_pend;
                        r_state <= ST_RUN;
                    end
                end
                default: begin
                    r_state <= ST_BOOT;
                end
            endcase

            if (w_accept) begin
                r_err <= r_err | {w_err_hi, w_err_lo};
                if (r_cnt != c_cnt_max) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule
`default_nettype wire
